uart_tx_sched: RTL and testbench

UART_TX_SCHED -- requirements
Module: uart_tx_sched

---
 rtl/uart_tx_sched.sv | 91 +++++++++
 tb/tb_uart_tx_sched.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler for four requesters, sending each 16-bit word
// as a header/data byte frame through a UART byte engine.
module uart_tx_sched #(
    parameter int TIMEOUT = 20000,
    parameter int HEADER  = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  req,
    input  logic [63:0] req_data,
    output logic [3:0]  gnt,
    output logic [3:0]  ack,
    output logic [7:0]  tx_byte,
    output logic        tx_load,
    input  logic        tx_busy,
    output logic        busy,
    output logic        err,
    input  logic        clr_err
);
    typedef enum logic [2:0] {IDLE, LOAD, WAIT_START, WAIT_DONE, FINISH, ABORT} state_t;
    localparam logic [1:0] HI = (HEADER != 0) ? 2'd1 : 2'd0;
    localparam logic [1:0] LO = HI + 2'd1;
    state_t state, state_nxt;
    logic [1:0] ptr, id, idx, off, win;
    logic [3:0] rot;
    logic [15:0] data, timer;
    logic [7:0] cur_byte;
    logic timeout, last;

    // rot[k] is the request of requester ptr+k, so the first set bit is the winner
    assign rot = 4'({req, req} >> ptr);
    assign off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
    assign win = ptr + off;
    assign timeout = timer == 16'(TIMEOUT - 1);
    assign last = idx == LO;
    assign cur_byte = (idx == HI) ? data[15:8] : (idx == LO) ? data[7:0] : {4'hA, 2'b00, id};
    assign tx_load = state == LOAD && !tx_busy;
    assign tx_byte = tx_load ? cur_byte : 8'h00;
    assign busy = state != IDLE;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       state_nxt = |req ? LOAD : IDLE;
            LOAD:       state_nxt = tx_busy ? LOAD : WAIT_START;
            WAIT_START: state_nxt = timeout ? ABORT : tx_busy ? WAIT_DONE : WAIT_START;
            WAIT_DONE:  state_nxt = timeout ? ABORT : tx_busy ? WAIT_DONE : last ? FINISH : LOAD;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            ptr   <= 2'd0;
            id    <= 2'd0;
            idx   <= 2'd0;
            data  <= 16'h0000;
            timer <= 16'h0000;
            gnt   <= 4'h0;
            ack   <= 4'h0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            ack   <= 4'h0;
            if (state == IDLE && |req) begin
                gnt  <= 4'b0001 << win;
                id   <= win;
                data <= req_data[{win, 4'b0000} +: 16];
                idx  <= 2'd0;
            end
            // the timer spans both wait phases of a byte and restarts only on a load
            if (tx_load)
                timer <= 16'h0000;
            else if ((state == WAIT_START || state == WAIT_DONE) && state_nxt == state)
                timer <= timer + 16'd1;
            if (state == WAIT_DONE && state_nxt == LOAD)
                idx <= idx + 2'd1;
            if (state == FINISH || state == ABORT) begin
                gnt <= 4'h0;
                ptr <= id + 2'd1;
            end
            if (state == FINISH)
                ack <= 4'b0001 << id;
            if (state == ABORT)
                err <= 1'b1;
            else if (clr_err)
                err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed checks of two scheduler instances (default frame, and
// HEADER=0 with TIMEOUT=16) against hand-computed byte streams, grants and acks.
module tb_uart_tx_sched;
    logic clk = 1'b0, reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] req_a = 4'h0, req_b = 4'h0, gnt_a, gnt_b, ack_a, ack_b;
    logic [63:0] data_a = '0, data_b = '0;
    logic [7:0] byte_a, byte_b;
    logic load_a, load_b, tbusy_a, tbusy_b, busy_a, busy_b, err_a, err_b;
    logic clr_a = 1'b0, clr_b = 1'b0, en_b = 1'b1, force_b = 1'b0, pl_a = 1'b0, pl_b = 1'b0;
    int cnt_a = 0, cnt_b = 0, blen_a = 20, blen_b = 3, viol = 0, nack_a = 0, nack_b = 0;
    int ncmp = 0, nfail = 0;
    logic [7:0] q_a[$], q_b[$];

    uart_tx_sched u_a (
        .clk(clk), .reset_n(reset_n), .req(req_a), .req_data(data_a), .gnt(gnt_a), .ack(ack_a),
        .tx_byte(byte_a), .tx_load(load_a), .tx_busy(tbusy_a), .busy(busy_a), .err(err_a),
        .clr_err(clr_a)
    );
    uart_tx_sched #(.TIMEOUT(16), .HEADER(0)) u_b (
        .clk(clk), .reset_n(reset_n), .req(req_b), .req_data(data_b), .gnt(gnt_b), .ack(ack_b),
        .tx_byte(byte_b), .tx_load(load_b), .tx_busy(tbusy_b), .busy(busy_b), .err(err_b),
        .clr_err(clr_b)
    );

    // byte engine models plus protocol monitors
    assign tbusy_a = cnt_a != 0;
    assign tbusy_b = force_b || cnt_b != 0;
    always @(posedge clk) begin
        if (load_a) begin
            q_a.push_back(byte_a);
            cnt_a <= blen_a;
        end else if (cnt_a > 0) cnt_a <= cnt_a - 1;
        if (load_b) begin
            q_b.push_back(byte_b);
            if (en_b) cnt_b <= blen_b;
        end else if (cnt_b > 0) cnt_b <= cnt_b - 1;
        if ((load_a && (pl_a || tbusy_a)) || (load_b && (pl_b || tbusy_b)) ||
            !$onehot0(gnt_a) || !$onehot0(gnt_b) || !$onehot0(ack_a) || !$onehot0(ack_b))
            viol <= viol + 1;
        pl_a <= load_a;
        pl_b <= load_b;
        if (ack_a != 0) nack_a <= nack_a + 1;
        if (ack_b != 0) nack_b <= nack_b + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_ack(input bit b, output int k);
        k = 0;
        while ((b ? ack_b : ack_a) == 4'h0 && k < 2000) begin
            @(negedge clk);
            k++;
        end
    endtask

    // single request: grant after one cycle, req dropped and data scrambled while granted
    task automatic txn(input bit b, input string nm, input logic [3:0] r, input logic [15:0] w,
                       input int nb, input logic [23:0] exp);
        logic [63:0] d;
        logic [7:0] got;
        int n0, k, gbad;
        gbad = 0;
        for (int i = 0; i < 4; i++) d[16*i +: 16] = r[i] ? w : 16'hDEAD;
        @(negedge clk);
        if (b) begin q_b.delete(); data_b = d; req_b = r; n0 = nack_b; end
        else begin q_a.delete(); data_a = d; req_a = r; n0 = nack_a; end
        @(negedge clk);
        chk({nm, ".gnt"}, b ? gnt_b : gnt_a, r);
        if (b) begin req_b = 4'h0; data_b = '1; end
        else begin req_a = 4'h0; data_a = '1; end
        k = 0;
        while ((b ? ack_b : ack_a) == 4'h0 && k < 2000) begin
            if ((b ? gnt_b : gnt_a) != r) gbad++;
            @(negedge clk);
            k++;
        end
        chk({nm, ".ack"}, b ? ack_b : ack_a, r);
        chk({nm, ".gnt_held"}, gbad, 0);
        chk({nm, ".gnt_drop"}, b ? gnt_b : gnt_a, 0);
        @(negedge clk);
        chk({nm, ".ack_pulse"}, b ? ack_b : ack_a, 0);
        chk({nm, ".nack"}, (b ? nack_b : nack_a) - n0, 1);
        chk({nm, ".nbytes"}, b ? q_b.size() : q_a.size(), nb);
        for (int i = 0; i < nb; i++) begin
            got = b ? q_b[i] : q_a[i];
            chk($sformatf("%s.byte%0d", nm, i), got, exp[23-8*i -: 8]);
        end
    endtask

    typedef struct {
        string nm;
        bit b;
        logic [3:0] r;
        logic [15:0] w;
        int blen;
        int nb;
        logic [23:0] exp;
    } vec_t;

    initial begin
        vec_t tbl[6];
        int k, ng, pid, loads;
        int ord[5];
        logic [3:0] pg, pack;
        tbl[0] = '{"single_r2", 1'b0, 4'b0100, 16'h1234, 20, 3, 24'hA21234};
        tbl[1] = '{"single_r0", 1'b0, 4'b0001, 16'h00FF, 1, 3, 24'hA000FF};
        tbl[2] = '{"single_r3", 1'b0, 4'b1000, 16'h8001, 5, 3, 24'hA38001};
        tbl[3] = '{"single_r1", 1'b0, 4'b0010, 16'hA55A, 7, 3, 24'hA1A55A};
        tbl[4] = '{"nohdr_beef", 1'b1, 4'b0100, 16'hBEEF, 3, 2, 24'hBEEF00};
        tbl[5] = '{"nohdr_fe01", 1'b1, 4'b1000, 16'hFE01, 2, 2, 24'hFE0100};

        #1;
        chk("rst.gnt", gnt_a, 0);
        chk("rst.ack", ack_a, 0);
        chk("rst.load", load_a, 0);
        chk("rst.byte", byte_a, 0);
        chk("rst.busy", busy_a, 0);
        chk("rst.err", err_a, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            if (tbl[i].b) blen_b = tbl[i].blen; else blen_a = tbl[i].blen;
            txn(tbl[i].b, tbl[i].nm, tbl[i].r, tbl[i].w, tbl[i].nb, tbl[i].exp);
        end

        // reset during the second byte, then round-robin from requester 0
        blen_a = 20;
        q_a.delete();
        @(negedge clk);
        data_a = {16'h0000, 16'h0000, 16'hC3D4, 16'h0000};
        req_a = 4'b0010;
        @(negedge clk);
        req_a = 4'h0;
        k = 0;
        while (q_a.size() < 2 && k < 500) begin @(negedge clk); k++; end
        chk("arst.second_byte", q_a.size(), 2);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("arst.gnt", gnt_a, 0);
        chk("arst.ack", ack_a, 0);
        chk("arst.load", load_a, 0);
        chk("arst.byte", byte_a, 0);
        chk("arst.busy", busy_a, 0);
        @(negedge clk);
        reset_n = 1'b1;

        blen_a = 2;
        q_a.delete();
        data_a = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        req_a = 4'hF;
        ng = 0;
        pid = 0;
        pg = 4'h0;
        pack = 4'h0;
        k = 0;
        while (ng < 5 && k < 2000) begin
            @(negedge clk);
            k++;
            if (gnt_a != 0 && pg == 0) begin
                if (ng > 0) chk($sformatf("rr.ack_before_gnt%0d", ng), pack, 4'b0001 << pid);
                for (int i = 0; i < 4; i++) if (gnt_a[i]) pid = i;
                ord[ng] = pid;
                ng++;
            end
            pg = gnt_a;
            pack = ack_a;
        end
        req_a = 4'h0;
        chk("rr.grants", ng, 5);
        chk("rr.order0", ord[0], 0);
        chk("rr.order1", ord[1], 1);
        chk("rr.order2", ord[2], 2);
        chk("rr.order3", ord[3], 3);
        chk("rr.order4", ord[4], 0);
        k = 0;
        while (busy_a && k < 500) begin @(negedge clk); k++; end
        chk("rr.nbytes", q_a.size(), 15);
        chk("rr.first_header", q_a[0], 8'hA0);
        chk("rr.first_hi", q_a[1], 8'h11);
        chk("rr.second_header", q_a[3], 8'hA1);

        // engine never responds: abort after the timer expires, set beats clear
        en_b = 1'b0;
        @(negedge clk);
        k = nack_b;
        data_b = {4{16'h1111}};
        req_b = 4'b0100;
        @(negedge clk);
        chk("to.gnt", gnt_b, 4'b0100);
        req_b = 4'h0;
        chk("to.load", load_b, 1);
        loads = 0;
        repeat (16) begin
            @(negedge clk);
            if (err_b || gnt_b != 4'b0100 || !busy_b) loads++;
        end
        chk("to.waiting", loads, 0);
        @(negedge clk);
        chk("to.abort_err", err_b, 0);
        chk("to.abort_gnt", gnt_b, 4'b0100);
        clr_b = 1'b1;
        @(negedge clk);
        clr_b = 1'b0;
        chk("to.err_set_wins", err_b, 1);
        chk("to.gnt_drop", gnt_b, 0);
        chk("to.idle", busy_b, 0);
        chk("to.no_ack", nack_b - k, 0);
        clr_b = 1'b1;
        @(negedge clk);
        clr_b = 1'b0;
        chk("to.err_clr", err_b, 0);
        en_b = 1'b1;

        // engine busy at grant: load held off for 50 cycles without a timeout
        q_b.delete();
        force_b = 1'b1;
        @(negedge clk);
        data_b = {16'h0, 16'h0, 16'h0, 16'h1357};
        req_b = 4'b0001;
        @(negedge clk);
        chk("hold.gnt", gnt_b, 4'b0001);
        req_b = 4'h0;
        loads = 0;
        repeat (50) begin
            @(negedge clk);
            if (load_b) loads++;
        end
        chk("hold.no_load", loads + q_b.size(), 0);
        chk("hold.err", err_b, 0);
        chk("hold.gnt_held", gnt_b, 4'b0001);
        force_b = 1'b0;
        wait_ack(1'b1, k);
        chk("hold.ack", ack_b, 4'b0001);
        chk("hold.err_end", err_b, 0);
        chk("hold.nbytes", q_b.size(), 2);
        chk("hold.byte0", q_b[0], 8'h13);
        chk("hold.byte1", q_b[1], 8'h57);

        @(negedge clk);
        chk("monitor.protocol", viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
